booth_result_sequencer: RTL and testbench

Control-and-buffer stage wrapped around the Booth multiplier. It issues the one-cycle `finish` pulse that advances the multiplier to its next operation. After a fixed latency it captures the multiplier's 64-bit `result` and queues it in a small first-word-fall-through FIFO. Downstream logic drains the FIFO through a valid/ready handshake. It replaces bench-driven `finish` stimulus, so multiplier runs can be sequenced in RTL.

---
 rtl/booth_result_sequencer.sv | 141 ++++++++++++++
 tb/tb_booth_result_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_result_sequencer.sv
// Sequences Booth multiplier runs: issues a one-cycle finish pulse, waits a fixed
// latency, captures the product into a first-word-fall-through FIFO for a valid/ready consumer.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_IDLE    | waiting for en with FIFO space; decision made here
//   S_PULSE   | finish high for exactly this cycle; wait counter loaded
//   S_WAIT    | down-counting to terminal count (WAIT_CYCLES cycles)
//   S_CAPTURE | result_in pushed to FIFO and op_count bumped at cycle end
module booth_result_sequencer #(
    parameter int DATA_W      = 64,
    parameter int WAIT_CYCLES = 40,
    parameter int DEPTH       = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    output logic                         finish,
    input  logic [DATA_W-1:0]            result_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
    output logic [15:0]                  op_count,
    output logic                         busy
);

    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = 10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PULSE,
        S_WAIT,
        S_CAPTURE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               en_q;
    logic               finish_q, busy_q, out_valid_q;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [15:0]        op_count_q, op_count_d;
    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic               push, pop;

    // en is registered, so the issue decision sees the value sampled at the previous edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (en_q && (level_q < LVL_W'(DEPTH))) begin
                    state_d = S_PULSE;
                end
            end
            S_PULSE: begin
                cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_CAPTURE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign push = (state_q == S_CAPTURE);
    assign pop  = out_valid_q && out_ready;

    always_comb begin
        level_d    = level_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        op_count_d = op_count_q;
        if (push) begin
            wr_ptr_d   = wr_ptr_q + PTR_W'(1);
            op_count_d = op_count_q + 16'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            en_q        <= 1'b0;
            finish_q    <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            level_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            en_q        <= en;
            finish_q    <= (state_d == S_PULSE);
            busy_q      <= (state_d != S_IDLE);
            out_valid_q <= (level_d != '0);
            level_q     <= level_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            op_count_q  <= op_count_d;
        end
    end

    // Storage needs no reset: out_valid gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= result_in;
        end
    end

    assign finish     = finish_q;
    assign busy       = busy_q;
    assign out_valid  = out_valid_q;
    assign fifo_level = level_q;
    assign op_count   = op_count_q;
    assign out_data   = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_booth_result_sequencer.sv
// Bench for booth_result_sequencer: behavioural Booth stub plus a scoreboard whose
// expected products are queued at each finish pulse and popped by a separate monitor.
module tb_booth_result_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, en, out_ready, finish, out_valid, busy;
    logic [63:0] result_in, out_data;
    logic [2:0]  fifo_level;
    logic [15:0] op_count;

    int cyc = 0, n_cmp = 0, n_err = 0;
    int fin_cnt = 0, wr_idx = 0, rd_idx = 0, pop_cnt = 0;
    int fin_cyc [64];
    logic [63:0] exp_mem [64];

    // n*(n+1) for n = 1..20
    logic [63:0] prod_tab [20] = '{64'd2, 64'd6, 64'd12, 64'd20, 64'd30, 64'd42, 64'd56,
                                   64'd72, 64'd90, 64'd110, 64'd132, 64'd156, 64'd182,
                                   64'd210, 64'd240, 64'd272, 64'd306, 64'd342, 64'd380, 64'd420};

    booth_result_sequencer #(.DATA_W(64), .WAIT_CYCLES(40), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .finish(finish), .result_in(result_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .fifo_level(fifo_level), .op_count(op_count), .busy(busy)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [63:0] prod(input int n);
        if (n >= 1 && n <= 20) return prod_tab[n-1];
        return 64'(n) * 64'(n + 1);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int k = 1);
        repeat (k) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Booth stub + scoreboard push: product appears 30 cycles after each finish pulse.
    initial begin
        int n, timer;
        n = 0;
        timer = 0;
        result_in = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                n = 0; timer = 0; fin_cnt = 0; wr_idx = 0;
            end else if (finish) begin
                n++;
                fin_cyc[fin_cnt % 64] = cyc;
                fin_cnt++;
                exp_mem[wr_idx % 64] = prod(n);
                wr_idx++;
                timer = 30;
            end else if (timer > 0) begin
                timer--;
                if (timer == 0) result_in = prod(n);
            end
        end
    end

    // Monitor: every accepted head entry is compared with the oldest expected product.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            rd_idx = 0; pop_cnt = 0;
        end else if (out_valid && out_ready) begin
            if (rd_idx == wr_idx) begin
                n_cmp++; n_err++;
                $display("FAIL spurious pop: got 0x%0h, want no entry", out_data);
            end else begin
                chk("out_data order", out_data, exp_mem[rd_idx % 64]);
            end
            rd_idx++;
            pop_cnt++;
        end
    end

    task automatic wait_fin(input int target, input int budget);
        int t = 0;
        while (fin_cnt < target && t < budget) begin tick(); t++; end
        n_cmp++;
        if (fin_cnt < target) begin
            n_err++;
            $display("FAIL finish wait: got %0d pulses, want %0d", fin_cnt, target);
        end
    endtask

    task automatic wait_pops(input int target, input int budget);
        int t = 0;
        while (pop_cnt < target && t < budget) begin tick(); t++; end
        n_cmp++;
        if (pop_cnt < target) begin
            n_err++;
            $display("FAIL pop wait: got %0d pops, want %0d", pop_cnt, target);
        end
    endtask

    task automatic wait_level(input int target, input int budget);
        int t = 0;
        while (int'(fifo_level) != target && t < budget) begin tick(); t++; end
        chk("fifo_level wait", 64'(fifo_level), 64'(target));
    endtask

    task automatic wait_valid(input int budget);
        int t = 0;
        while (!out_valid && t < budget) begin tick(); t++; end
        chk("out_valid wait", 64'(out_valid), 64'd1);
    endtask

    task automatic do_reset();
        en = 1'b0; out_ready = 1'b0;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " finish"}, 64'(finish), 64'd0);
        chk({tag, " busy"}, 64'(busy), 64'd0);
        chk({tag, " out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, " fifo_level"}, 64'(fifo_level), 64'd0);
        chk({tag, " op_count"}, 64'(op_count), 64'd0);
    endtask

    initial begin
        #400us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, p, f, t, k;
        logic [15:0] prev;
        rst_n = 1'b0; en = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick(2);

        // single op: en sampled at edge e, finish at e+1, out_valid after e+43
        en = 1'b1;
        tick();
        e = cyc;
        en = 1'b0;
        wait_valid(80);
        chk("capture latency", 64'(cyc), 64'(e + 43));
        chk("finish issue edge", 64'(fin_cyc[0]), 64'(e + 1));
        chk("single out_data", out_data, 64'd2);
        chk("single fifo_level", 64'(fifo_level), 64'd1);
        chk("single op_count", 64'(op_count), 64'd1);
        tick(10);
        chk("single pulse count", 64'(fin_cnt), 64'd1);

        // back-to-back with consumer always ready
        do_reset();
        out_ready = 1'b1; en = 1'b1;
        wait_fin(5, 300);
        en = 1'b0;
        wait_pops(5, 120);
        for (int i = 1; i < 5; i++) chk("finish spacing", 64'(fin_cyc[i] - fin_cyc[i-1]), 64'd43);
        chk("b2b drained", 64'(out_valid), 64'd0);
        chk("b2b op_count", 64'(op_count), 64'd5);

        // full stall, then single pop releases the 5th issue
        do_reset();
        en = 1'b1;
        wait_fin(4, 250);
        wait_level(4, 60);
        tick(100);
        chk("stall pulses", 64'(fin_cnt), 64'd4);
        chk("stall level", 64'(fifo_level), 64'd4);
        chk("stall busy", 64'(busy), 64'd0);
        out_ready = 1'b1;
        tick();
        p = cyc;
        out_ready = 1'b0;
        wait_fin(5, 10);
        en = 1'b0;
        chk("issue after pop", 64'(fin_cyc[4]), 64'(p + 1));

        // push and pop together on the capture edge
        f = fin_cyc[4];
        t = 0;
        while (cyc < f + 41 && t < 60) begin tick(); t++; end
        chk("pre push/pop level", 64'(fifo_level), 64'd3);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("push/pop level", 64'(fifo_level), 64'd3);
        chk("push/pop op_count", 64'(op_count), 64'd5);
        out_ready = 1'b1;
        wait_pops(5, 20);
        chk("drain valid", 64'(out_valid), 64'd0);
        chk("drain scoreboard", 64'(rd_idx), 64'(wr_idx));

        // en dropped during WAIT: operation still completes
        do_reset();
        en = 1'b1;
        tick();
        en = 1'b0;
        tick(10);
        chk("en drop busy", 64'(busy), 64'd1);
        wait_valid(60);
        chk("en drop idle", 64'(busy), 64'd0);
        chk("en drop op_count", 64'(op_count), 64'd1);
        tick(60);
        chk("en drop pulses", 64'(fin_cnt), 64'd1);

        // reset during WAIT aborts immediately
        en = 1'b1;
        tick();
        en = 1'b0;
        tick(10);
        chk("mid-op busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("async reset");
        tick(2);
        rst_n = 1'b1;
        tick(60);
        chk_all_zero("no capture");

        // reset during PULSE drops finish asynchronously
        en = 1'b1;
        tick();
        en = 1'b0;
        tick();
        chk("pulse high", 64'(finish), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("pulse aborted", 64'(finish), 64'd0);
        tick(2);
        rst_n = 1'b1;
        tick();

        // op_count wrap and FIFO pointer wrap with a bursty consumer
        do_reset();
        force dut.op_count_q = 16'hFFFE;
        tick();
        release dut.op_count_q;
        tick();
        chk("preload op_count", 64'(op_count), 64'hFFFE);
        prev = 16'hFFFE;
        k = 0;
        t = 0;
        en = 1'b1;
        while (!(k >= 14 && pop_cnt >= 14) && t < 4000) begin
            tick();
            t++;
            if (fin_cnt >= 14) en = 1'b0;
            if (op_count != prev) begin
                k++;
                chk("op_count step", 64'(op_count), 64'(16'(32'hFFFE + k)));
                prev = op_count;
            end
            out_ready = (k >= 14) ? 1'b1 : (((cyc / 37) % 3) == 0);
        end
        chk("wrap captures", 64'(k), 64'd14);
        chk("wrap pops", 64'(pop_cnt), 64'd14);
        chk("wrap op_count", 64'(op_count), 64'h000C);
        chk("wrap scoreboard", 64'(rd_idx), 64'(wr_idx));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
